// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: shared frontend types for the fetch-to-decode queue.
package decode_queue_pkg;
    typedef enum logic [2:0] {
        OP_ALU, OP_MUL, OP_DIV, OP_LOAD, OP_STORE, OP_BRANCH, OP_CSR, OP_MISC
    } optype_t;
    typedef enum logic [2:0] {
        EXCP_NONE, EXCP_ADEF, EXCP_TLBR, EXCP_PIF, EXCP_PPI
    } excp_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_br_taken;
        logic [31:0] pred_br_target;
        logic        fetch_excp;
        excp_t       fetch_excp_type;
    } fetch_entry_t;
endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch push side and decode pop side of the instruction queue.
interface decode_queue_if import decode_queue_pkg::*; #(parameter int DEPTH = 8);
    logic [1:0]              in_valid;
    fetch_entry_t            in_entry0;
    fetch_entry_t            in_entry1;
    logic                    in_ready;
    logic [1:0]              out_valid;
    fetch_entry_t            out_entry0;
    fetch_entry_t            out_entry1;
    logic [1:0]              out_accept;
    logic [$clog2(DEPTH):0]  count;
    modport master (output in_valid, in_entry0, in_entry1, out_accept,
                    input in_ready, out_valid, out_entry0, out_entry1, count);
    modport slave (input in_valid, in_entry0, in_entry1, out_accept,
                   output in_ready, out_valid, out_entry0, out_entry1, count);
endinterface

// File: rtl/decode_queue_ring_ram.sv
// dual_port_ring_ram: unreset entry storage with two write ports and two async read ports.
module dual_port_ring_ram import decode_queue_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0,
    input  logic          we1,
    input  logic [IW-1:0] waddr0,
    input  logic [IW-1:0] waddr1,
    input  fetch_entry_t  wdata0,
    input  fetch_entry_t  wdata1,
    input  logic [IW-1:0] raddr0,
    input  logic [IW-1:0] raddr1,
    output fetch_entry_t  rdata0,
    output fetch_entry_t  rdata1
);
    fetch_entry_t mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end
    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];
endmodule

// File: rtl/decode_queue.sv
// decode_queue: dual-issue circular instruction queue between fetch and decode.
// Occupancy is tail-head; the extra pointer MSB separates full from empty.
module decode_queue import decode_queue_pkg::*; #(
    parameter int DEPTH = 8
) (
    input logic           clk,
    input logic           reset,
    input logic           flush,
    decode_queue_if.slave q
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, count;
    logic [IW-1:0] wa1, ra1;
    logic [1:0]    pn, qn, valid;
    logic          ready;
    always_comb begin
        count  = tail_q - head_q;
        ready  = count <= PW'(DEPTH - 2);
        valid  = {count >= PW'(2), count != '0};
        pn     = ready ? (q.in_valid[1] ? 2'd2 : {1'b0, q.in_valid[0]}) : 2'd0;
        // an illegal accept of 2'b10 pops nothing because slot 1 requires slot 0
        qn     = {1'b0, q.out_accept[0] & valid[0]}
               + {1'b0, q.out_accept[0] & q.out_accept[1] & valid[1]};
        head_d = flush ? '0 : head_q + PW'(qn);
        tail_d = flush ? '0 : tail_q + PW'(pn);
        wa1    = tail_q[IW-1:0] + IW'(1);
        ra1    = head_q[IW-1:0] + IW'(1);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
    assign q.in_ready  = ready;
    assign q.out_valid = valid;
    assign q.count     = count;
    dual_port_ring_ram #(.DEPTH(DEPTH)) u_ram (
        .clk    (clk),
        .we0    (!flush && pn != 2'd0),
        .we1    (!flush && pn[1]),
        .waddr0 (tail_q[IW-1:0]),
        .waddr1 (wa1),
        .wdata0 (q.in_entry0),
        .wdata1 (q.in_entry1),
        .raddr0 (head_q[IW-1:0]),
        .raddr1 (ra1),
        .rdata0 (q.out_entry0),
        .rdata1 (q.out_entry1)
    );
endmodule
